// File: rtl/riscv_pkg.sv
// Shared opcodes and enumerations for the multi-cycle RISC-V control path.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } ctrl_state_t;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0,
        PC_IMM   = 2'd1,
        PC_ALU   = 2'd2
    } pc_src_t;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2,
        WB_IMM  = 2'd3
    } wb_sel_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_SYSTEM,
        CLS_ILLEGAL
    } instr_class_t;

endpackage

// File: rtl/riscv_ctrl_decode.sv
// Opcode decoder: instruction class plus the datapath operand/writeback selects.
module riscv_ctrl_decode
    import riscv_pkg::*;
(
    input  logic [6:0]   opcode,
    output instr_class_t instr_class,
    output logic         alu_a_pc,
    output logic         alu_b_imm,
    output wb_sel_t      wb_sel
);

    // Map each opcode to its class and selects; anything unlisted is illegal.
    always_comb begin
        instr_class = CLS_ILLEGAL;
        alu_a_pc    = 1'b0;
        alu_b_imm   = 1'b0;
        wb_sel      = WB_ALU;
        case (opcode)
            OP_R: begin
                instr_class = CLS_ALU;
            end
            OP_IMM: begin
                instr_class = CLS_ALU;
                alu_b_imm   = 1'b1;
            end
            OP_LOAD: begin
                instr_class = CLS_LOAD;
                alu_b_imm   = 1'b1;
                wb_sel      = WB_LOAD;
            end
            OP_STORE: begin
                instr_class = CLS_STORE;
                alu_b_imm   = 1'b1;
            end
            OP_BRANCH: begin
                instr_class = CLS_BRANCH;
            end
            OP_JAL: begin
                instr_class = CLS_JAL;
                alu_a_pc    = 1'b1;
                alu_b_imm   = 1'b1;
                wb_sel      = WB_PC4;
            end
            OP_JALR: begin
                instr_class = CLS_JALR;
                alu_b_imm   = 1'b1;
                wb_sel      = WB_PC4;
            end
            OP_LUI: begin
                instr_class = CLS_ALU;
                wb_sel      = WB_IMM;
            end
            OP_AUIPC: begin
                instr_class = CLS_ALU;
                alu_a_pc    = 1'b1;
                alu_b_imm   = 1'b1;
            end
            OP_SYSTEM: begin
                instr_class = CLS_SYSTEM;
            end
            default: begin
                instr_class = CLS_ILLEGAL;
            end
        endcase
    end

endmodule

// File: rtl/riscv_ctrl_fsm.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with sticky HALT,
// memory wait counter and retired-instruction counter.
module riscv_ctrl_fsm
    import riscv_pkg::*;
#(
    parameter int MEM_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        branch_taken,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        alu_a_pc,
    output logic        alu_b_imm,
    output logic        rd_we,
    output logic [1:0]  wb_sel,
    output logic        mem_write_en,
    output logic        halted,
    output logic        illegal,
    output logic [31:0] instret
);

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    ctrl_state_t  state_q, state_d;
    logic [3:0]   wait_q, wait_d;
    logic [31:0]  instret_q, instret_d;
    logic         illegal_q, illegal_d;

    instr_class_t dec_class;
    logic         dec_a_pc;
    logic         dec_b_imm;
    wb_sel_t      dec_wb_sel;
    logic         wait_done;
    logic         retire;
    logic         ir_we_c;

    // SYSTEM halts whether it is ECALL or EBREAK, so funct3 does not steer anything.
    logic unused_funct3;
    assign unused_funct3 = ^funct3;

    riscv_ctrl_decode u_decode (
        .opcode      (opcode),
        .instr_class (dec_class),
        .alu_a_pc    (dec_a_pc),
        .alu_b_imm   (dec_b_imm),
        .wb_sel      (dec_wb_sel)
    );

    assign wait_done = (wait_q == WAIT_LAST);

    // Next-state, wait counter, retire and all datapath controls for the current state.
    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        illegal_d    = illegal_q;
        retire       = 1'b0;
        ir_we_c      = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PC_PLUS4;
        rd_we        = 1'b0;
        mem_write_en = 1'b0;
        alu_a_pc     = 1'b0;
        alu_b_imm    = 1'b0;
        wb_sel       = WB_ALU;

        if (state_q inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) begin
            alu_a_pc  = dec_a_pc;
            alu_b_imm = dec_b_imm;
            wb_sel    = dec_wb_sel;
        end

        case (state_q)
            ST_FETCH: begin
                if (wait_done) begin
                    ir_we_c = 1'b1;
                    wait_d  = 4'd0;
                    state_d = ST_DECODE;
                end else begin
                    wait_d  = wait_q + 4'd1;
                end
            end
            ST_DECODE: begin
                case (dec_class)
                    CLS_SYSTEM:  state_d = ST_HALT;
                    CLS_ILLEGAL: begin
                        state_d   = ST_HALT;
                        illegal_d = 1'b1;
                    end
                    default:     state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                case (dec_class)
                    CLS_BRANCH: begin
                        pc_we   = 1'b1;
                        pc_src  = branch_taken ? PC_IMM : PC_PLUS4;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                    default:             state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                mem_write_en = (dec_class == CLS_STORE);
                if (wait_done) begin
                    wait_d = 4'd0;
                    if (dec_class == CLS_STORE) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            ST_WB: begin
                rd_we   = 1'b1;
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_d = ST_FETCH;
                if (dec_class == CLS_JAL) begin
                    pc_src = PC_IMM;
                end else if (dec_class == CLS_JALR) begin
                    pc_src = PC_ALU;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
                wait_d  = 4'd0;
            end
        endcase

        instret_d = instret_q + {31'd0, retire};
    end

    // State, wait counter, sticky illegal flag and retire counter registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= ST_FETCH;
            wait_q    <= 4'd0;
            instret_q <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
        end
    end

    // Reset leaves the FSM sitting in FETCH, so the fetch strobe is masked while reset is held.
    assign ir_we   = ir_we_c & rst_b;
    assign halted  = (state_q == ST_HALT);
    assign illegal = illegal_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_riscv_ctrl_fsm.sv
// Testbench for riscv_ctrl_fsm: two instances (MEM_WAIT 0 and 2) checked cycle by
// cycle against a per-instruction schedule built from the cycle-count rules.
module tb_riscv_ctrl_fsm;

    localparam int W_A = 0;
    localparam int W_B = 2;

    typedef struct packed {
        logic        ir_we;
        logic        pc_we;
        logic [1:0]  pc_src;
        logic        alu_a_pc;
        logic        alu_b_imm;
        logic        rd_we;
        logic [1:0]  wb_sel;
        logic        mem_write_en;
        logic        halted;
        logic        illegal;
        logic [31:0] instret;
    } obs_t;

    typedef struct {
        obs_t       exp;
        logic [6:0] op;
        logic       taken;
    } step_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_b_a, rst_b_b;
    logic [6:0]  opcode_a, opcode_b;
    logic [2:0]  funct3_a, funct3_b;
    logic        taken_a, taken_b;
    logic        ir_we_a, pc_we_a, alu_a_pc_a, alu_b_imm_a, rd_we_a, mem_we_a, halted_a, illegal_a;
    logic        ir_we_b, pc_we_b, alu_a_pc_b, alu_b_imm_b, rd_we_b, mem_we_b, halted_b, illegal_b;
    logic [1:0]  pc_src_a, wb_sel_a, pc_src_b, wb_sel_b;
    logic [31:0] instret_a, instret_b;

    riscv_ctrl_fsm #(.MEM_WAIT(W_A)) dut_a (
        .clk(clk), .rst_b(rst_b_a), .opcode(opcode_a), .funct3(funct3_a),
        .branch_taken(taken_a), .ir_we(ir_we_a), .pc_we(pc_we_a), .pc_src(pc_src_a),
        .alu_a_pc(alu_a_pc_a), .alu_b_imm(alu_b_imm_a), .rd_we(rd_we_a), .wb_sel(wb_sel_a),
        .mem_write_en(mem_we_a), .halted(halted_a), .illegal(illegal_a), .instret(instret_a)
    );

    riscv_ctrl_fsm #(.MEM_WAIT(W_B)) dut_b (
        .clk(clk), .rst_b(rst_b_b), .opcode(opcode_b), .funct3(funct3_b),
        .branch_taken(taken_b), .ir_we(ir_we_b), .pc_we(pc_we_b), .pc_src(pc_src_b),
        .alu_a_pc(alu_a_pc_b), .alu_b_imm(alu_b_imm_b), .rd_we(rd_we_b), .wb_sel(wb_sel_b),
        .mem_write_en(mem_we_b), .halted(halted_b), .illegal(illegal_b), .instret(instret_b)
    );

    int    vectors = 0;
    int    miscompares = 0;
    step_t trace[$];
    logic [31:0] model_ret[2];
    int    first_irwe, first_rd, first_halt, mem_cnt, n_cyc;

    // Gather one instance's outputs into a single comparable vector.
    function automatic obs_t sample(input bit which);
        obs_t o;
        if (!which) begin
            o = '{ir_we_a, pc_we_a, pc_src_a, alu_a_pc_a, alu_b_imm_a, rd_we_a, wb_sel_a,
                  mem_we_a, halted_a, illegal_a, instret_a};
        end else begin
            o = '{ir_we_b, pc_we_b, pc_src_b, alu_a_pc_b, alu_b_imm_b, rd_we_b, wb_sel_b,
                  mem_we_b, halted_b, illegal_b, instret_b};
        end
        return o;
    endfunction

    function automatic void push_step(input obs_t e, input logic [6:0] op, input logic taken);
        step_t s;
        s.exp   = e;
        s.op    = op;
        s.taken = taken;
        trace.push_back(s);
    endfunction

    // Expected per-cycle outputs of one instruction, from the phase lengths and select rules.
    function automatic void build(input bit which, input logic [6:0] op, input logic taken,
                                  input int halt_cycles);
        int   w      = which ? W_B : W_A;
        bit   is_ld  = (op == 7'h03);
        bit   is_st  = (op == 7'h23);
        bit   is_br  = (op == 7'h63);
        bit   is_jal = (op == 7'h6F);
        bit   is_jr  = (op == 7'h67);
        bit   is_sys = (op == 7'h73);
        bit   known  = op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73};
        obs_t idle, sel, e;
        idle = '0;
        idle.instret = model_ret[which];
        sel = idle;
        sel.alu_a_pc  = op inside {7'h17, 7'h6F};
        sel.alu_b_imm = op inside {7'h13, 7'h03, 7'h23, 7'h67, 7'h17, 7'h6F};
        sel.wb_sel    = is_ld ? 2'd1 : (is_jal || is_jr) ? 2'd2 : (op == 7'h37) ? 2'd3 : 2'd0;
        trace.delete();
        for (int i = 0; i < w; i++) push_step(idle, op, taken);
        e = idle;
        e.ir_we = 1'b1;
        push_step(e, op, taken);
        push_step(sel, op, taken);
        if (is_sys || !known) begin
            e = idle;
            e.halted  = 1'b1;
            e.illegal = !known;
            for (int i = 0; i < halt_cycles; i++) push_step(e, op, taken);
            return;
        end
        if (is_br) begin
            e = sel;
            e.pc_we  = 1'b1;
            e.pc_src = taken ? 2'd1 : 2'd0;
            push_step(e, op, taken);
            model_ret[which] = model_ret[which] + 32'd1;
            return;
        end
        push_step(sel, op, taken);
        if (is_ld || is_st) begin
            for (int i = 0; i <= w; i++) begin
                e = sel;
                e.mem_write_en = is_st;
                e.pc_we        = is_st && (i == w);
                push_step(e, op, taken);
            end
        end
        if (is_st) begin
            model_ret[which] = model_ret[which] + 32'd1;
            return;
        end
        e = sel;
        e.rd_we  = 1'b1;
        e.pc_we  = 1'b1;
        e.pc_src = is_jal ? 2'd1 : is_jr ? 2'd2 : 2'd0;
        push_step(e, op, taken);
        model_ret[which] = model_ret[which] + 32'd1;
    endfunction

    task automatic check_output(input bit which, input obs_t exp, input string name);
        obs_t got = sample(which);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s dut%0d t=%0t: got %h want %h", name, which, $time, got, exp);
        end
    endtask

    task automatic check_literal(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic drive(input bit which, input logic [6:0] op, input logic taken);
        if (!which) begin
            opcode_a = op;
            taken_a  = taken;
        end else begin
            opcode_b = op;
            taken_b  = taken;
        end
    endtask

    // Play the current schedule from posedge+1; optionally assert reset mid-instruction.
    task automatic apply_stimulus(input bit which, input int abort_at);
        obs_t got;
        obs_t zero = '0;
        first_irwe = -1;
        first_rd   = -1;
        first_halt = -1;
        mem_cnt    = 0;
        n_cyc      = 0;
        for (int k = 0; k < trace.size(); k++) begin
            drive(which, trace[k].op, trace[k].taken);
            @(negedge clk);
            check_output(which, trace[k].exp, "cycle");
            check_output(!which, zero, "idle_in_reset");
            got = sample(which);
            if (got.ir_we && first_irwe < 0) first_irwe = k;
            if (got.rd_we && first_rd < 0) first_rd = k;
            if (got.halted && first_halt < 0) first_halt = k;
            if (got.mem_write_en) mem_cnt++;
            n_cyc++;
            if (k == abort_at) begin
                #1;
                if (!which) rst_b_a = 1'b0; else rst_b_b = 1'b0;
                model_ret[which] = 32'd0;
                #1;
                check_output(which, zero, "abort_reset");
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Hold reset for two cycles, checking the reset state, then release just after an edge.
    task automatic do_reset(input bit which);
        obs_t zero = '0;
        if (!which) rst_b_a = 1'b0; else rst_b_b = 1'b0;
        drive(which, 7'h33, 1'b0);
        @(posedge clk);
        repeat (2) begin
            @(negedge clk);
            check_output(which, zero, "reset_state");
        end
        @(posedge clk);
        #1;
        if (!which) rst_b_a = 1'b1; else rst_b_b = 1'b1;
        model_ret[which] = 32'd0;
    endtask

    task automatic run_instr(input bit which, input logic [6:0] op, input logic taken,
                             input int halt_cycles);
        build(which, op, taken, halt_cycles);
        apply_stimulus(which, -1);
    endtask

    // Directed program: MEM_WAIT=0 instance first, then the MEM_WAIT=2 instance.
    initial begin
        rst_b_a  = 1'b0;
        rst_b_b  = 1'b0;
        opcode_a = 7'h33;
        opcode_b = 7'h33;
        funct3_a = 3'd0;
        funct3_b = 3'd0;
        taken_a  = 1'b0;
        taken_b  = 1'b0;

        do_reset(1'b0);
        run_instr(1'b0, 7'h33, 1'b0, 0);
        check_literal("r_first_ir_we_cycle", first_irwe, 0);
        check_literal("r_rd_we_cycle", first_rd, 3);
        check_literal("r_cycles", n_cyc, 4);
        check_literal("r_instret", int'(instret_a), 1);
        run_instr(1'b0, 7'h03, 1'b0, 0);
        check_literal("w0_load_cycles", n_cyc, 5);
        run_instr(1'b0, 7'h23, 1'b0, 0);
        check_literal("w0_store_mem_cycles", mem_cnt, 1);
        run_instr(1'b0, 7'h63, 1'b1, 0);
        check_literal("w0_branch_cycles", n_cyc, 3);
        run_instr(1'b0, 7'h6F, 1'b0, 0);
        run_instr(1'b0, 7'h73, 1'b0, 20);
        check_literal("system_halt_cycle", first_halt, 2);
        check_literal("system_illegal", int'(illegal_a), 0);
        check_literal("system_instret", int'(instret_a), 5);
        rst_b_a = 1'b0;

        do_reset(1'b1);
        run_instr(1'b1, 7'h03, 1'b0, 0);
        check_literal("load_rd_we_cycle", first_rd, 8);
        check_literal("load_cycles", n_cyc, 9);
        run_instr(1'b1, 7'h23, 1'b0, 0);
        check_literal("store_mem_we_cycles", mem_cnt, 3);
        check_literal("store_no_rd_we", first_rd, -1);
        check_literal("store_cycles", n_cyc, 8);
        run_instr(1'b1, 7'h63, 1'b1, 0);
        check_literal("branch_cycles", n_cyc, 5);
        run_instr(1'b1, 7'h63, 1'b0, 0);
        run_instr(1'b1, 7'h6F, 1'b0, 0);
        run_instr(1'b1, 7'h67, 1'b0, 0);
        run_instr(1'b1, 7'h37, 1'b0, 0);
        run_instr(1'b1, 7'h17, 1'b0, 0);
        run_instr(1'b1, 7'h13, 1'b0, 0);
        check_literal("w2_instret", int'(instret_b), 9);

        do_reset(1'b1);
        build(1'b1, 7'h23, 1'b0, 0);
        apply_stimulus(1'b1, 6);
        check_literal("abort_instret", int'(instret_b), 0);
        check_literal("abort_halted", int'(halted_b), 0);
        do_reset(1'b1);
        run_instr(1'b1, 7'h33, 1'b0, 0);
        check_literal("after_abort_instret", int'(instret_b), 1);
        run_instr(1'b1, 7'h7F, 1'b0, 20);
        check_literal("illegal_halt_cycle", first_halt, 4);
        check_literal("illegal_flag", int'(illegal_b), 1);
        check_literal("illegal_instret", int'(instret_b), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
